// File: rtl/ccip_if_pkg.sv
// CCI-P MMIO channel types used by the MMIO host (subset of the platform package).
package ccip_if_pkg;

   typedef logic [8:0]   t_ccip_tid;
   typedef logic [15:0]  t_ccip_mmioAddr;
   typedef logic [63:0]  t_ccip_mmioData;
   typedef logic [511:0] t_ccip_clData;

   typedef struct packed {
      t_ccip_mmioAddr address;
      logic [1:0]     length;
      logic           rsvd;
      t_ccip_tid      tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMmioHdr hdr;
      t_ccip_clData        data;
      logic                rspValid;
      logic                mmioRdValid;
      logic                mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_tid tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      t_ccip_mmioData      data;
   } t_if_ccip_c2_Tx;

endpackage

// File: rtl/sha512_pkg.sv
// Shared state type and MMIO encodings for the SHA-512 MMIO host.
package sha512_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      WAIT,
      RESP
   } t_mmio_host_state;

   // CCI-P MMIO length field: 0=4B, 1=8B, 2=64B
   localparam logic [1:0] MMIO_LEN_8B = 2'd1;

endpackage

// File: rtl/sha512_mmio_host.sv
// MMIO host: turns simple host commands into CCI-P MMIO requests toward the
// AFU CSR block and matches read responses by tid, with a read timeout.
module sha512_mmio_host
   import ccip_if_pkg::*;
   import sha512_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic           cmd_write,
   input  logic [15:0]    cmd_addr,
   input  logic [63:0]    cmd_wdata,
   output t_if_ccip_c0_Rx rx_mmio_channel,
   input  t_if_ccip_c2_Tx tx_mmio_channel,
   output logic           rsp_valid,
   output logic [63:0]    rsp_data,
   output logic           rsp_timeout,
   output logic [15:0]    stale_cnt
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   t_mmio_host_state state, state_nxt;
   logic [15:0]      addr_q;
   logic [63:0]      wdata_q;
   logic [8:0]       tid_q;
   logic [8:0]       out_tid_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_q;
   logic             rsp_match;
   logic             wait_last;

   assign cmd_ready   = (state == IDLE) && !reset;
   assign rsp_match   = (state == WAIT) && tx_mmio_channel.mmioRdValid &&
                        (tx_mmio_channel.hdr.tid == out_tid_q);
   assign wait_last   = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign rsp_valid   = (state == RESP);
   assign rsp_timeout = (state == RESP) && timeout_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a match in the last WAIT cycle takes priority over timeout
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid && cmd_ready) state_nxt = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  state_nxt = IDLE;
         RD_REQ:  state_nxt = WAIT;
         WAIT:    if (rsp_match || wait_last) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request channel is driven purely from registered command fields and state
   always_comb begin
      rx_mmio_channel                = '0;
      rx_mmio_channel.hdr.address    = addr_q;
      rx_mmio_channel.hdr.length     = MMIO_LEN_8B;
      rx_mmio_channel.hdr.tid        = tid_q;
      rx_mmio_channel.data[63:0]     = wdata_q;
      rx_mmio_channel.mmioWrValid    = (state == WR_REQ);
      rx_mmio_channel.mmioRdValid    = (state == RD_REQ);
      rx_mmio_channel.rspValid       = 1'b0;
   end

   // Command capture, tid sequencing, wait timer, completion and stale counting
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         tid_q     <= '0;
         out_tid_q <= '0;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
         rsp_data  <= '0;
         stale_cnt <= '0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
         end
         if (state == WR_REQ || state == RD_REQ) tid_q <= tid_q + 9'd1;
         if (state == RD_REQ) begin
            out_tid_q <= tid_q;
            wait_cnt  <= '0;
         end
         if (state == WAIT) begin
            if (rsp_match) begin
               rsp_data  <= tx_mmio_channel.data;
               timeout_q <= 1'b0;
            end else if (wait_last) begin
               rsp_data  <= '0;
               timeout_q <= 1'b1;
            end else begin
               wait_cnt  <= wait_cnt + 1'b1;
            end
         end
         if (tx_mmio_channel.mmioRdValid && !rsp_match && stale_cnt != 16'hFFFF)
            stale_cnt <= stale_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_sha512_mmio_host.sv
// Directed testbench for sha512_mmio_host with a one-cycle-latency CSR responder.
module tb_sha512_mmio_host;
   import ccip_if_pkg::*;
   import sha512_pkg::*;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic           cmd_write = 1'b0;
   logic [15:0]    cmd_addr = '0;
   logic [63:0]    cmd_wdata = '0;
   t_if_ccip_c0_Rx rx_ch;
   t_if_ccip_c2_Tx tx_ch;
   logic           rsp_valid;
   logic [63:0]    rsp_data;
   logic           rsp_timeout;
   logic [15:0]    stale_cnt;

   int total = 0;
   int bad   = 0;
   int both_high = 0;

   logic       resp_en = 1'b1;
   logic [8:0] tid_xor = '0;
   logic       inject_req = 1'b0;
   logic [8:0] inject_tid = '0;

   sha512_mmio_host #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rx_mmio_channel(rx_ch), .tx_mmio_channel(tx_ch),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .stale_cnt(stale_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] csr_val(input logic [15:0] a);
      case (a)
         16'h0000: csr_val = 64'h1000010000000000;
         16'h0002: csr_val = 64'hC000C9660D824272;
         16'h0004: csr_val = 64'h9AEFFE5F84570612;
         default:  csr_val = 64'hA5A5000000000000 | {48'h0, a};
      endcase
   endfunction

   // AFU CSR responder: answers a read one cycle after the request
   always @(posedge clk) begin
      if (reset) begin
         tx_ch <= '0;
      end else begin
         tx_ch.mmioRdValid <= 1'b0;
         if (rx_ch.mmioRdValid && resp_en) begin
            tx_ch.mmioRdValid <= 1'b1;
            tx_ch.hdr.tid     <= rx_ch.hdr.tid ^ tid_xor;
            tx_ch.data        <= csr_val(rx_ch.hdr.address);
         end else if (inject_req) begin
            tx_ch.mmioRdValid <= 1'b1;
            tx_ch.hdr.tid     <= inject_tid;
            tx_ch.data        <= 64'h5555AAAA5555AAAA;
         end
      end
   end

   // Watch for simultaneous read and write request valids
   always @(posedge clk) if (rx_ch.mmioWrValid && rx_ch.mmioRdValid) both_high++;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      resp_en = 1'b1;
      tid_xor = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Presents one command; returns at the negedge of cycle N+1 (accept at N)
   task automatic issue(input logic wr, input logic [15:0] a, input logic [63:0] d,
                        output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
      end
      if (ok) begin
         cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
         @(negedge clk);
         cmd_valid = 1'b0;
      end
   endtask

   // Read with latency measured in cycles after acceptance (0 = no completion)
   task automatic do_read(input logic [15:0] a, output logic [63:0] data,
                          output logic to, output int lat, output logic [8:0] rtid);
      logic ok;
      lat = 0; data = '0; to = 1'b0; rtid = '0;
      issue(1'b0, a, 64'h0, ok);
      if (ok) begin
         rtid = rx_ch.hdr.tid;
         for (int k = 2; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
               lat = k; data = rsp_data; to = rsp_timeout;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
      total++; if ({rx_ch.mmioWrValid, rx_ch.mmioRdValid, rx_ch.rspValid} !== 3'b000) begin bad++; $display("FAIL reset_rx_valids got=%b want=000", {rx_ch.mmioWrValid, rx_ch.mmioRdValid, rx_ch.rspValid}); end
      total++; if ({rsp_valid, rsp_timeout} !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%b want=00", {rsp_valid, rsp_timeout}); end
      total++; if (rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
      total++; if (stale_cnt !== 16'h0) begin bad++; $display("FAIL reset_stale got=%0d want=0", stale_cnt); end
      total++; if (rx_ch.hdr.tid !== 9'd0) begin bad++; $display("FAIL reset_tid got=%0d want=0", rx_ch.hdr.tid); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready); end
   endtask

   task automatic test_write();
      logic ok;
      do_reset();
      issue(1'b1, 16'h0020, 64'hDEAD, ok);
      total++; if (!ok) begin bad++; $display("FAIL wr_accept got=timeout want=accepted"); end
      total++; if ({rx_ch.mmioWrValid, rx_ch.mmioRdValid} !== 2'b10) begin bad++; $display("FAIL wr_valid got=%b want=10", {rx_ch.mmioWrValid, rx_ch.mmioRdValid}); end
      total++; if (rx_ch.hdr.address !== 16'h0020) begin bad++; $display("FAIL wr_addr got=%h want=0020", rx_ch.hdr.address); end
      total++; if (rx_ch.data[63:0] !== 64'hDEAD) begin bad++; $display("FAIL wr_data got=%h want=dead", rx_ch.data[63:0]); end
      total++; if (rx_ch.hdr.tid !== 9'd0) begin bad++; $display("FAIL wr_tid got=%0d want=0", rx_ch.hdr.tid); end
      total++; if (rx_ch.hdr.length !== 2'd1) begin bad++; $display("FAIL wr_len got=%0d want=1", rx_ch.hdr.length); end
      @(negedge clk);
      total++; if (rx_ch.mmioWrValid !== 1'b0) begin bad++; $display("FAIL wr_one_cycle got=%b want=0", rx_ch.mmioWrValid); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_n2 got=%b want=1", cmd_ready); end
   endtask

   task automatic test_csr_reads();
      logic [63:0] d; logic to; int lat; logic [8:0] t;
      logic [15:0] addrs [3];
      addrs[0] = 16'h0000; addrs[1] = 16'h0002; addrs[2] = 16'h0004;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         do_read(addrs[i], d, to, lat, t);
         total++; if (lat != 3) begin bad++; $display("FAIL rd_latency addr=%h got=%0d want=3", addrs[i], lat); end
         total++; if (d !== csr_val(addrs[i])) begin bad++; $display("FAIL rd_data addr=%h got=%h want=%h", addrs[i], d, csr_val(addrs[i])); end
         total++; if (to !== 1'b0) begin bad++; $display("FAIL rd_timeout addr=%h got=%b want=0", addrs[i], to); end
         total++; if (t !== 9'(i)) begin bad++; $display("FAIL rd_tid got=%0d want=%0d", t, i); end
         @(negedge clk);
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_one_cycle got=%b want=0", rsp_valid); end
         total++; if (rsp_data !== csr_val(addrs[i])) begin bad++; $display("FAIL rsp_hold got=%h want=%h", rsp_data, csr_val(addrs[i])); end
      end
   endtask

   task automatic test_timeout();
      logic [63:0] d; logic to; int lat; logic [8:0] t;
      do_reset();
      resp_en = 1'b0;
      do_read(16'h0000, d, to, lat, t);
      resp_en = 1'b1;
      total++; if (lat != 18) begin bad++; $display("FAIL to_latency got=%0d want=18", lat); end
      total++; if (to !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", to); end
      total++; if (d !== 64'h0) begin bad++; $display("FAIL to_data got=%h want=0", d); end
      total++; if (stale_cnt !== 16'd0) begin bad++; $display("FAIL to_stale got=%0d want=0", stale_cnt); end
   endtask

   task automatic test_stale_tid();
      logic [63:0] d; logic to; int lat; logic [8:0] t;
      do_reset();
      tid_xor = 9'h001;
      do_read(16'h0002, d, to, lat, t);
      tid_xor = '0;
      total++; if (stale_cnt !== 16'd1) begin bad++; $display("FAIL stale_cnt got=%0d want=1", stale_cnt); end
      total++; if (lat != 18) begin bad++; $display("FAIL stale_latency got=%0d want=18", lat); end
      total++; if (to !== 1'b1) begin bad++; $display("FAIL stale_timeout got=%b want=1", to); end
      total++; if (d !== 64'h0) begin bad++; $display("FAIL stale_data got=%h want=0", d); end
   endtask

   task automatic test_tid_wrap();
      logic [63:0] d; logic to; int lat; logic [8:0] t;
      logic [15:0] a;
      do_reset();
      for (int i = 0; i < 513; i++) begin
         a = 16'((i % 3) * 2);
         do_read(a, d, to, lat, t);
         total++; if (t !== 9'(i)) begin bad++; $display("FAIL wrap_tid i=%0d got=%0d want=%0d", i, t, i % 512); end
         total++; if (d !== csr_val(a) || to !== 1'b0 || lat != 3) begin bad++; $display("FAIL wrap_rsp i=%0d got=%h/%b/%0d want=%h/0/3", i, d, to, lat, csr_val(a)); end
      end
      total++; if (stale_cnt !== 16'd0) begin bad++; $display("FAIL wrap_stale got=%0d want=0", stale_cnt); end
   endtask

   task automatic test_back_to_back();
      logic ok; logic [8:0] wt; logic [63:0] d; logic to; int lat; logic [8:0] t;
      do_reset();
      issue(1'b1, 16'h0004, 64'h0123456789ABCDEF, ok);
      wt = rx_ch.hdr.tid;
      total++; if (!ok || rx_ch.mmioWrValid !== 1'b1) begin bad++; $display("FAIL b2b_write got=%b want=1", rx_ch.mmioWrValid); end
      do_read(16'h0004, d, to, lat, t);
      total++; if (wt !== 9'd0 || t !== 9'd1) begin bad++; $display("FAIL b2b_tids got=%0d,%0d want=0,1", wt, t); end
      total++; if (d !== csr_val(16'h0004) || lat != 3) begin bad++; $display("FAIL b2b_read got=%h/%0d want=%h/3", d, lat, csr_val(16'h0004)); end
      total++; if (both_high != 0) begin bad++; $display("FAIL wr_rd_exclusive got=%0d want=0", both_high); end
   endtask

   task automatic test_reset_in_wait();
      logic ok; logic [63:0] d; logic to; int lat; logic [8:0] t; logic [8:0] old_tid;
      int seen;
      do_reset();
      do_read(16'h0002, d, to, lat, t);
      resp_en = 1'b0;
      issue(1'b0, 16'h0006, 64'h0, ok);
      old_tid = rx_ch.hdr.tid;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b0 || rsp_data !== 64'h0) begin bad++; $display("FAIL rw_reset_state got=%b/%h want=0/0", cmd_ready, rsp_data); end
      reset = 1'b0;
      resp_en = 1'b1;
      inject_tid = old_tid;
      inject_req = 1'b1;
      @(negedge clk);
      inject_req = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL rw_no_completion got=%0d want=0", seen); end
      total++; if (stale_cnt !== 16'd1) begin bad++; $display("FAIL rw_stale got=%0d want=1", stale_cnt); end
      total++; if (old_tid !== 9'd1) begin bad++; $display("FAIL rw_old_tid got=%0d want=1", old_tid); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_csr_reads();
      test_timeout();
      test_stale_tid();
      test_back_to_back();
      test_reset_in_wait();
      test_tid_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
